// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_if
//  Description : Instruction ROM bus between the sequencer and its program ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
    logic [4:0]  address;
    logic [22:0] code;

    modport master (output address, input code);
    modport slave  (input address, output code);
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC sequencer with an 8x16 register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    instr_sequencer_if.master  rom,
    input  logic [2:0]         rd_sel,
    output logic [15:0]        rd_data,
    output logic [2:0]         state,
    output logic               done,
    output logic               illegal,
    output logic               carry
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_HALT   = 3'b100
    } state_t;

    localparam logic [3:0] c_OP_HALT = 4'b0000;
    localparam logic [3:0] c_OP_LOAD = 4'b0001;
    localparam logic [3:0] c_OP_MOV  = 4'b0010;
    localparam logic [3:0] c_OP_ADD  = 4'b0011;

    state_t      r_state;
    logic [4:0]  r_pc;
    logic [22:0] r_ir;
    logic [15:0] r_regs [8];
    logic        r_done;
    logic        r_illegal;
    logic        r_carry;

    logic [3:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [15:0] w_imm;
    logic [16:0] w_sum;

    assign w_op  = r_ir[22:19];
    assign w_rx  = r_ir[18:16];
    assign w_ry  = r_ir[15:13];
    assign w_imm = r_ir[15:0];
    // Operands come from the pre-edge register values, so Rx=Ry reads the old value.
    assign w_sum = {1'b0, r_regs[w_rx]} + {1'b0, r_regs[w_ry]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_carry   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir <= rom.code;
                    if (rom.code[22:19] == c_OP_HALT) begin
                        r_state <= S_HALT;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_LOAD: r_regs[w_rx] <= w_imm;
                        c_OP_MOV:  r_regs[w_rx] <= r_regs[w_ry];
                        c_OP_ADD: begin
                            r_regs[w_rx] <= w_sum[15:0];
                            r_carry      <= w_sum[16];
                        end
                        default:   r_illegal <= 1'b1;
                    endcase
                    r_pc    <= r_pc + 5'd1;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom.address = r_pc;
    assign rd_data     = r_regs[rd_sel];
    assign state       = r_state;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign carry       = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed scoreboard bench for instr_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [2:0]  rd_sel = 3'd0;
    logic [15:0] rd_data;
    logic [2:0]  state;
    logic        done;
    logic        illegal;
    logic        carry;
    logic [22:0] rom [32];

    instr_sequencer_if bus ();
    assign bus.code = rom[bus.address];

    instr_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .rom     (bus),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .state   (state),
        .done    (done),
        .illegal (illegal),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc;

    function automatic logic [22:0] op_load(input logic [2:0] rx, input logic [15:0] imm);
        return {4'b0001, rx, imm};
    endfunction

    function automatic logic [22:0] op_mov(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0010, rx, ry, 13'd0};
    endfunction

    function automatic logic [22:0] op_add(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0011, rx, ry, 13'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_reg(input logic [2:0] sel, input logic [15:0] exp);
        sb_t e;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_sel = e.sel;
            #1;
            check($sformatf("R%0d", e.sel), 32'(rd_data), 32'(e.exp));
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 32; i++) rom[i] = 23'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int k = 0;
        while (state !== s && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic count_to_done(input int max, output int c);
        c = 0;
        while (done !== 1'b1 && c < max) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic load_ref();
        logic [15:0] vals [8];
        vals = '{16'd12, 16'd9, 16'd3, 16'd20, 16'd13, 16'd21, 16'd25, 16'd30};
        rom_clear();
        for (int i = 0; i < 8; i++) rom[i] = op_load(3'(i), vals[i]);
        rom[8]  = op_mov(3'd0, 3'd4);
        rom[9]  = op_mov(3'd5, 3'd7);
        rom[10] = op_mov(3'd2, 3'd1);
        rom[11] = op_add(3'd3, 3'd0);
        rom[12] = 23'd0;
    endtask

    task automatic push_ref();
        push_reg(3'd0, 16'd13);
        push_reg(3'd1, 16'd9);
        push_reg(3'd2, 16'd9);
        push_reg(3'd3, 16'd33);
        push_reg(3'd4, 16'd13);
        push_reg(3'd5, 16'd30);
        push_reg(3'd6, 16'd25);
        push_reg(3'd7, 16'd30);
    endtask

    initial begin
        rom_clear();

        // Reset values, observed while rst_n is still low.
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        for (int i = 0; i < 8; i++) push_reg(3'(i), 16'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", 32'(state), 32'd0);

        // Reference program.
        load_ref();
        push_ref();
        run = 1'b1;
        wait_state(3'd1, 5, "ref_first_fetch");
        count_to_done(100, cyc);
        check("ref_done_latency", 32'(cyc), 32'd38);
        check("ref_state_halt", 32'(state), 32'd4);
        check("ref_address", 32'(bus.address), 32'd12);
        check("ref_carry", 32'(carry), 32'd0);
        check("ref_illegal", 32'(illegal), 32'd0);
        drain();
        repeat (2) @(negedge clk);
        check("halt_hold_state", 32'(state), 32'd4);
        check("halt_hold_addr", 32'(bus.address), 32'd12);

        // Restart from HALT.
        run = 1'b0;
        @(negedge clk);
        check("restart_idle", 32'(state), 32'd0);
        check("restart_addr0", 32'(bus.address), 32'd0);
        check("restart_done_low", 32'(done), 32'd0);
        run = 1'b1;
        @(negedge clk);
        check("restart_fetch", 32'(state), 32'd1);
        push_ref();
        count_to_done(100, cyc);
        check("rerun_latency", 32'(cyc), 32'd38);
        drain();

        // Carry, with run dropped mid-program.
        do_reset();
        rom_clear();
        rom[0] = op_load(3'd1, 16'hFFFF);
        rom[1] = op_load(3'd2, 16'h0001);
        rom[2] = op_add(3'd1, 3'd2);
        rom[3] = op_load(3'd4, 16'h0055);
        push_reg(3'd1, 16'h0000);
        push_reg(3'd2, 16'h0001);
        push_reg(3'd4, 16'h0055);
        run = 1'b1;
        wait_state(3'd1, 5, "carry_first_fetch");
        run = 1'b0;
        count_to_done(60, cyc);
        check("carry_done_latency", 32'(cyc), 32'd14);
        check("carry_after_load", 32'(carry), 32'd1);
        drain();
        @(negedge clk);
        check("carry_idle_after_halt", 32'(state), 32'd0);
        check("carry_addr0", 32'(bus.address), 32'd0);

        // Illegal opcode.
        do_reset();
        rom_clear();
        rom[0] = {4'b0111, 3'd3, 16'h00AA};
        push_reg(3'd3, 16'd0);
        push_reg(3'd0, 16'd0);
        run = 1'b1;
        wait_state(3'd3, 10, "ill_reach_exec");
        check("ill_before_exec", 32'(illegal), 32'd0);
        @(negedge clk);
        check("ill_after_exec", 32'(illegal), 32'd1);
        count_to_done(10, cyc);
        check("ill_halt_latency", 32'(cyc), 32'd2);
        check("ill_halt_addr", 32'(bus.address), 32'd1);
        drain();
        run = 1'b0;
        @(negedge clk);
        check("ill_sticky", 32'(illegal), 32'd1);

        // Reset during EXEC of LOAD R3.
        do_reset();
        check("ill_cleared_by_reset", 32'(illegal), 32'd0);
        rom_clear();
        rom[0] = op_load(3'd3, 16'h1234);
        run = 1'b1;
        wait_state(3'd3, 10, "rst_reach_exec");
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_address", 32'(bus.address), 32'd0);
        rd_sel = 3'd3;
        #1;
        check("midrst_r3", 32'(rd_data), 32'd0);
        @(negedge clk);
        check("midrst_r3_after_edge", 32'(rd_data), 32'd0);
        run   = 1'b0;
        rst_n = 1'b1;

        // PC wrap with no HALT in the program.
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = op_load(3'(i % 8), 16'(i + 100));
        run = 1'b1;
        begin
            int k = 0;
            while (!(state == 3'd1 && bus.address == 5'd31) && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("wrap_reach31", 32'(bus.address), 32'd31);
        repeat (3) @(negedge clk);
        check("wrap_fetch_state", 32'(state), 32'd1);
        check("wrap_to_zero", 32'(bus.address), 32'd0);
        push_reg(3'd7, 16'd131);
        push_reg(3'd0, 16'd124);
        drain();
        wait_state(3'd1, 3, "wrap_refetch");
        repeat (3) @(negedge clk);
        check("wrap_continue_addr", 32'(bus.address), 32'd1);
        check("wrap_no_done", 32'(done), 32'd0);
        push_reg(3'd0, 16'd100);
        drain();
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port run, input, 1 bit: start/enable execution.
REQ-005 Port address, output, 5 bits: program counter driven to the instruction ROM.
REQ-006 Port code, input, 23 bits: instruction word from the ROM, combinational with respect to address.
REQ-007 Port rd_sel, input, 3 bits: debug register select.
REQ-008 Port rd_data, output, 16 bits: combinational read of register R[rd_sel].
REQ-009 Port state, output, 3 bits: current FSM state encoding.
REQ-010 Port done, output, 1 bit: high while in HALT.
REQ-011 Port illegal, output, 1 bit: sticky flag for an unrecognised opcode.
REQ-012 Port carry, output, 1 bit: carry out of the last ADD.

Function
REQ-013 Instruction field decode SHALL be:
- opcode = code[22:19]
- Rx = code[18:16]
- Ry = code[15:13]
- imm = code[15:0]
REQ-014 The register file SHALL hold 8 registers of 16 bits each.
REQ-015 Opcodes SHALL execute as follows:
- 0001 LOAD: Rx <= imm
- 0010 MOV: Rx <= Ry
- 0011 ADD: Rx <= Rx + Ry (mod 2^16), carry <= bit 16 of the sum
- 0000 HALT
REQ-016 Any other opcode SHALL perform no register write, set illegal, and advance the PC like a normal instruction.
REQ-017 FSM states and encodings SHALL be IDLE=000, FETCH=001, DECODE=010, EXEC=011, HALT=100.
REQ-018 IDLE SHALL go to FETCH when run=1, and otherwise remain in IDLE.
REQ-019 FETCH SHALL drive address=pc and go to DECODE unconditionally.
REQ-020 DECODE SHALL latch code into the instruction register; if opcode=0000 it SHALL go to HALT, otherwise to EXEC.
REQ-021 EXEC SHALL perform the register write, set pc <= pc+1, and go to FETCH.
REQ-022 HALT SHALL hold pc and the registers and remain in HALT while run=1; when run=0 it SHALL go to IDLE and clear pc to 0.
REQ-023 Each non-HALT instruction SHALL take exactly 3 clocks (FETCH, DECODE, EXEC).
REQ-024 HALT SHALL be entered 2 clocks after its FETCH.
REQ-025 The PC SHALL wrap from 31 to 0 without a flag.
REQ-026 Deasserting run in FETCH, DECODE or EXEC SHALL have no effect; the sequencer continues until HALT.
REQ-027 For MOV and ADD with Rx=Ry, the old value of the register SHALL be used as the source operand.
REQ-028 A register write in EXEC SHALL be visible on rd_data in the cycle after EXEC.
REQ-029 carry SHALL be updated only by ADD; LOAD and MOV SHALL leave it unchanged.
REQ-030 illegal SHALL be cleared only by reset.
REQ-031 address SHALL equal pc in every state.

Reset
REQ-032 When rst_n=0, the following SHALL take effect immediately, independent of clk:
- state=IDLE, pc=0 (address=0)
- all R0..R7=0x0000
- instruction register=0
- done=0, illegal=0, carry=0
REQ-033 Reset asserted mid-instruction SHALL abort that instruction with no partial register write.
REQ-034 After rst_n rises, the block SHALL stay in IDLE until run=1 is sampled.

Verification
REQ-035 Reference program test: ROM program LOAD R0..R7 = 12,9,3,20,13,21,25,30; MOV R0,R4; MOV R5,R7; MOV R2,R1; ADD R3,R0; HALT at address 12; hold run=1.
- Required: done rises 38 clocks after the first FETCH.
- Final R0=13, R1=9, R2=9, R3=33, R4=13, R5=30, R6=25, R7=30.
- address=12, carry=0, illegal=0.
REQ-036 Carry test: LOAD R1 0xFFFF; LOAD R2 0x0001; ADD R1,R2; HALT.
- Required: R1=0x0000, carry=1.
- A following LOAD SHALL leave carry=1.
REQ-037 Illegal opcode test: opcode 0111 at address 0, HALT at address 1.
- Required: illegal=1 after the EXEC clock.
- No register changes; HALT is reached at address 1.
REQ-038 Reset mid-operation test: pulse rst_n low during EXEC of LOAD R3 0x1234.
- Required: R3=0, state=IDLE, address=0 without waiting for a clock edge.
REQ-039 HALT/restart test: from HALT, drop run for 1 clock, then raise it.
- Required: state goes HALT -> IDLE -> FETCH.
- address returns to 0 and the program re-executes.
REQ-040 Wrap test: ROM with no HALT (all LOAD instructions).
- Required: address steps 31 -> 0 and execution continues.
